// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. It accepts one operation per start pulse while
// ready is high. Single-cycle ops register their result on the accepting
// edge. Multiply runs N shift-add iterations in the MUL state. The result and
// its z/c flags are always written together, on the same edge that raises done.
module alu_seq #(
  parameter int N       = 16,
  parameter int W_INDEX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   alu_op,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] alu_out,
  output logic         z,
  output logic         c
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [N-1:0]     r_out;
  logic             r_z;
  logic             r_c;
  logic             r_done;

  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_last;
  logic [2*N-1:0]   w_acc_next;
  logic [N-1:0]     w_res;
  logic             w_carry;

  assign ready       = (r_state == S_IDLE);
  assign w_accept    = ready && start;
  assign w_mul_start = w_accept && (alu_op == 3'd2);
  // The iteration that brings the counter to N is the last one.
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CW'(N - 1));
  assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign alu_out = r_out;
  assign z       = r_z;
  assign c       = r_c;
  assign done    = r_done;

  // Single-cycle result and carry/borrow for every op except multiply
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (alu_op)
      3'd0:    {w_carry, w_res} = {1'b0, in1} + {1'b0, in2};
      3'd1: begin
        w_res   = in1 - in2;
        w_carry = (in1 < in2);
      end
      3'd3:    w_res = in1 << W_INDEX;
      3'd4:    w_res = in1 >> W_INDEX;
      3'd5:    w_res = in1 & in2;
      3'd6:    w_res = in1 | in2;
      3'd7:    w_res = in1 ^ in2;
      default: w_res = '0;
    endcase
  end

  // Next-state logic: enter MUL on an accepted multiply, leave after N iterations
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_next = S_MUL;
      S_MUL:   if (w_mul_last)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: operand capture, shift-add iterations, and the result/flag/done update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_z      <= 1'b1;
      r_c      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_mul_start) begin
          r_acc    <= '0;
          r_mcand  <= {{N{1'b0}}, in1};
          r_mplier <= in2;
          r_cnt    <= '0;
        end else if (w_accept) begin
          r_out  <= w_res;
          r_z    <= (w_res == '0);
          r_c    <= w_carry;
          r_done <= 1'b1;
        end
      end else begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_mul_last) begin
          r_out  <= w_acc_next[N-1:0];
          r_z    <= (w_acc_next[N-1:0] == '0);
          r_c    <= |w_acc_next[2*N-1:N];
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with N=8 and W_INDEX=3.
module tb_alu_seq;

  localparam int NN  = 8;
  localparam int WI  = 3;
  localparam int MOD = 1 << NN;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    alu_op;
  logic [NN-1:0] in1;
  logic [NN-1:0] in2;
  logic          ready;
  logic          done;
  logic [NN-1:0] alu_out;
  logic          z;
  logic          c;

  int total = 0;
  int bad   = 0;

  alu_seq #(.N(NN), .W_INDEX(WI)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
    .in1(in1), .in2(in2), .ready(ready), .done(done),
    .alu_out(alu_out), .z(z), .c(c)
  );

  always #5 clk = ~clk;

  // Reference model built from the operation table using plain integer arithmetic.
  // The return value is {carry, result}.
  function automatic logic [NN:0] ref_alu(input int op, input int a, input int b);
    int r;
    int cy;
    r  = 0;
    cy = 0;
    case (op)
      0: begin r = (a + b) % MOD; cy = (a + b >= MOD); end
      1: begin r = (a - b < 0) ? a - b + MOD : a - b; cy = (a < b); end
      2: begin r = (a * b) % MOD; cy = (a * b >= MOD); end
      3: r = (a * (1 << WI)) % MOD;
      4: r = a / (1 << WI);
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      default: r = 0;
    endcase
    return {cy[0], r[NN-1:0]};
  endfunction

  // Latency is counted so that the edge that samples start is edge 1.
  // rl counts the samples in which ready was low before done was seen.
  task automatic wait_done(output int lat, output int rl);
    lat = 1;
    rl  = 0;
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      if (!ready) rl++;
      if (done || lat >= 40) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [NN-1:0] a, input logic [NN-1:0] b,
                       output int lat, output int rl);
    @(negedge clk);
    start = 1'b1; alu_op = op; in1 = a; in2 = b;
    wait_done(lat, rl);
  endtask

  task automatic test_reset;
    int lat, rl;
    do_op(3'd0, 8'd200, 8'd100, lat, rl);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({alu_out, z, c, done, ready} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_async: got out=%0d z=%b c=%b done=%b ready=%b, want out=0 z=1 c=0 done=0 ready=1",
               alu_out, z, c, done, ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_addsub;
    int lat, rl;
    do_op(3'd0, 8'd200, 8'd100, lat, rl);
    total++;
    if ({alu_out, c, z} !== {8'd44, 1'b1, 1'b0} || lat != 1) begin
      bad++;
      $display("FAIL add_200_100: got out=%0d c=%b z=%b lat=%0d, want 44 1 0 lat=1", alu_out, c, z, lat);
    end
    do_op(3'd1, 8'd5, 8'd5, lat, rl);
    total++;
    if ({alu_out, c, z} !== {8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL sub_5_5: got out=%0d c=%b z=%b, want 0 0 1", alu_out, c, z);
    end
    do_op(3'd1, 8'd3, 8'd5, lat, rl);
    total++;
    if ({alu_out, c, z} !== {8'd254, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_3_5: got out=%0d c=%b z=%b, want 254 1 0", alu_out, c, z);
    end
  endtask

  task automatic test_random;
    int lat, rl, op, a, b;
    logic [NN:0] exp;
    for (int i = 0; i < 30; i++) begin
      op  = int'($urandom_range(0, 7));
      a   = int'($urandom_range(0, MOD - 1));
      b   = int'($urandom_range(0, MOD - 1));
      exp = ref_alu(op, a, b);
      do_op(op[2:0], a[NN-1:0], b[NN-1:0], lat, rl);
      total++;
      if ({alu_out, c, z} !== {exp[NN-1:0], exp[NN], exp[NN-1:0] == 0} ||
          lat != ((op == 2) ? NN + 1 : 1)) begin
        bad++;
        $display("FAIL random op=%0d a=%0d b=%0d: got out=%0d c=%b z=%b lat=%0d, want out=%0d c=%b lat=%0d",
                 op, a, b, alu_out, c, z, lat, exp[NN-1:0], exp[NN], (op == 2) ? NN + 1 : 1);
      end
    end
  endtask

  task automatic test_mul;
    int lat, rl, nd, first;
    logic [NN-1:0] r0;
    do_op(3'd2, 8'd13, 8'd11, lat, rl);
    total++;
    if ({alu_out, c, z} !== {8'd143, 1'b0, 1'b0} || lat != NN + 1 || rl != NN) begin
      bad++;
      $display("FAIL mul_13_11: got out=%0d c=%b z=%b lat=%0d ready_low=%0d, want 143 0 0 lat=9 ready_low=8",
               alu_out, c, z, lat, rl);
    end
    do_op(3'd2, 8'd20, 8'd20, lat, rl);
    total++;
    if ({alu_out, c, z} !== {8'd144, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mul_20_20: got out=%0d c=%b z=%b, want 144 1 0", alu_out, c, z);
    end
    // An add started during MUL must be dropped.
    @(negedge clk);
    start = 1'b1; alu_op = 3'd2; in1 = 8'd9; in2 = 8'd7;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    start = 1'b1; alu_op = 3'd0; in1 = 8'd1; in2 = 8'd1;
    nd = 0; first = 0; r0 = '0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) begin r0 = alu_out; first = k; end
      end
    end
    total++;
    if (nd != 1 || r0 !== 8'd63 || first != NN) begin
      bad++;
      $display("FAIL mul_ignore_start: got dones=%0d first_out=%0d at edge %0d, want 1 done out=63 at edge %0d",
               nd, r0, first, NN);
    end
  endtask

  task automatic test_throughput;
    logic [2:0]    ops [3];
    logic [NN-1:0] as  [3];
    logic [NN-1:0] bs  [3];
    logic [NN-1:0] exs [3];
    logic [NN:0]   exp;
    int op;
    ops = '{3'd3, 3'd4, 3'd7};
    as  = '{8'h15, 8'hA8, 8'hF0};
    bs  = '{8'h00, 8'h00, 8'hF0};
    exs = '{8'hA8, 8'h15, 8'h00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; alu_op = ops[i]; in1 = as[i]; in2 = bs[i];
      @(posedge clk); #1;
      total++;
      if (done !== 1'b1 || alu_out !== exs[i] || z !== (exs[i] == 0) || c !== 1'b0) begin
        bad++;
        $display("FAIL stream_%0d: got done=%b out=%h z=%b c=%b, want done=1 out=%h z=%b c=0",
                 i, done, alu_out, z, c, exs[i], exs[i] == 0);
      end
    end
    // Longer random stream of single-cycle ops
    for (int i = 0; i < 12; i++) begin
      do begin op = int'($urandom_range(0, 7)); end while (op == 2);
      @(negedge clk);
      start = 1'b1; alu_op = op[2:0];
      in1 = NN'($urandom_range(0, MOD - 1)); in2 = NN'($urandom_range(0, MOD - 1));
      exp = ref_alu(op, int'(in1), int'(in2));
      @(posedge clk); #1;
      total++;
      if (done !== 1'b1 || ready !== 1'b1 || alu_out !== exp[NN-1:0] || c !== exp[NN]) begin
        bad++;
        $display("FAIL rand_stream_%0d op=%0d: got done=%b ready=%b out=%0d c=%b, want done=1 ready=1 out=%0d c=%b",
                 i, op, done, ready, alu_out, c, exp[NN-1:0], exp[NN]);
      end
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL stream_end: got done=%b, want 0", done);
    end
  endtask

  task automatic test_back_to_back;
    int lat, rl;
    do_op(3'd2, 8'd13, 8'd11, lat, rl);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_issue_cycle: got done=%b ready=%b, want 1 1", done, ready);
    end
    start = 1'b1; alu_op = 3'd2; in1 = 8'd2; in2 = 8'd3;
    wait_done(lat, rl);
    total++;
    if ({alu_out, c, z} !== {8'd6, 1'b0, 1'b0} || lat != NN + 1) begin
      bad++;
      $display("FAIL b2b_mul_2_3: got out=%0d c=%b z=%b lat=%0d, want 6 0 0 lat=%0d", alu_out, c, z, lat, NN + 1);
    end
  endtask

  task automatic test_reset_mid_mul;
    int lat, rl, nd;
    @(negedge clk);
    start = 1'b1; alu_op = 3'd2; in1 = 8'd7; in2 = 8'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({alu_out, z, c, done, ready} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_mul: got out=%0d z=%b c=%b done=%b ready=%b, want 0 1 0 0 1",
               alu_out, z, c, done, ready);
    end
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    total++;
    if (nd != 0 || alu_out !== 8'd0 || z !== 1'b1) begin
      bad++;
      $display("FAIL abort_no_done: got dones=%0d out=%0d z=%b, want 0 0 1", nd, alu_out, z);
    end
    do_op(3'd0, 8'd1, 8'd1, lat, rl);
    total++;
    if ({alu_out, c, z} !== {8'd2, 1'b0, 1'b0} || lat != 1) begin
      bad++;
      $display("FAIL post_reset_add: got out=%0d c=%b z=%b lat=%0d, want 2 0 0 lat=1", alu_out, c, z, lat);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_op = '0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({alu_out, z, c, done, ready} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_initial: got out=%0d z=%b c=%b done=%b ready=%b, want 0 1 0 0 1",
               alu_out, z, c, done, ready);
    end
    @(negedge clk); rst = 1'b0;
    test_reset;
    test_addsub;
    test_mul;
    test_throughput;
    test_back_to_back;
    test_reset_mid_mul;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Handshaked, parametrised successor to the datapath ALU. It accepts one operation per `start` pulse and computes add, sub, mul, shift and logic ops on N-bit operands. Multiply is iterative shift-add; all other ops complete in one cycle. The result, zero flag and carry flag are registered together with a one-cycle `done` pulse, so `z` always describes the `alu_out` value it is presented with. The block sits between the controller FSM and the register file and replaces the free-running ALU.

## Interface
- `N`, 16: operand/result width; must be ≥ 2.
- `W_INDEX`, 4: constant shift distance for the shift ops; must be in 1..N-1.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only while `ready`=1.
- `alu_op`  in  3  operation code, captured with `start`.
- `in1`, `in2`  in  N  operands, captured with `start`.
- `ready`  out  1  block can accept `start` this cycle.
- `done`  out  1  one-cycle pulse: `alu_out`/`z`/`c` updated.
- `alu_out`  out  N  result, held until the next `done`.
- `z`  out  1  1 iff `alu_out`==0 (same update edge).
- `c`  out  1  carry or borrow flag (same update edge).

## Operation
- Op codes:
  - 0 add: `in1+in2` mod 2^N; `c` = carry out.
  - 1 sub: `in1-in2` mod 2^N; `c` = 1 iff `in1<in2` (unsigned borrow).
  - 2 mul: low N bits of the unsigned product; `c` = 1 iff any dropped high bit is nonzero.
  - 3 shl: `in1 << W_INDEX`.
  - 4 shr: `in1 >> W_INDEX`, logical.
  - 5 and, 6 or, 7 xor: bitwise on `in1`, `in2`.
  - For ops 3–7, `c` = 0.
- States:
  - IDLE: `ready`=1.
  - MUL: `ready`=0.
  - IDLE→MUL when `start`=1 and `alu_op`=2. All other ops stay in IDLE.
  - MUL→IDLE after exactly N iterations. No early termination.
- Multiply datapath:
  - The accepting edge loads: `acc`=0 (2N bits), `mcand`=`in1` (zero-extended to 2N), `mplier`=`in2`, iteration counter=0.
  - Each MUL edge: if `mplier[0]`, `acc += mcand`; then `mcand <<= 1`, `mplier >>= 1`, counter += 1.
  - The edge on which the counter reaches N writes the outputs.
- `start` while `ready`=0 is ignored: no capture, no queueing. Operands are not needed after the accepting edge.
- `alu_out`, `z` and `c` change only on edges that raise `done`. They are otherwise stable.

## Timing
- Reset values (asynchronous, immediate): `alu_out`=0, `z`=1, `c`=0, `done`=0, `ready`=1, state IDLE, multiply registers cleared.
- Latency is counted from the edge that samples `start` to the edge that raises `done`:
  - non-mul: 1 edge;
  - mul: N+1 edges.
- `ready` drops on the edge accepting a mul and rises on the edge that raises `done` for it. A new `start` is therefore legal in the cycle where `done`=1 (back-to-back mul issue).
- Non-mul ops keep `ready`=1, giving one result per cycle for consecutive starts. `done` stays high continuously in that case, and each high cycle carries the result of the op issued one cycle earlier.
- `rst` during MUL aborts the operation: no `done`, outputs return to reset values, and the first post-reset `start` is accepted normally.
- `rst` has priority over `start` on the same edge.

## Test plan
All scenarios use N=8, W_INDEX=3.
- Reset: assert `rst` mid-cycle → `alu_out`=0, `z`=1, `c`=0, `done`=0, `ready`=1 immediately, without waiting for a clock edge.
- Add/sub flags:
  - add 200+100 → `alu_out`=44, `c`=1, `z`=0, `done` one edge later.
  - sub 5-5 → 0, `z`=1, `c`=0.
  - sub 3-5 → 254, `c`=1.
- Multiply:
  - 13×11 → 143, `c`=0; `done` 9 edges after `start`; `ready`=0 for 8 cycles.
  - 20×20 → 144, `c`=1.
  - An add `start` issued during MUL is ignored (no extra `done`).
- Throughput:
  - Starts on consecutive cycles: shl 0x15 → 0xA8, shr 0xA8 → 0x15, xor 0xF0^0xF0 → 0 with `z`=1.
  - `done` is high for 3 consecutive cycles with the results in order.
- Back-to-back mul: issue a second mul (2×3) in the `done` cycle of the first → accepted; 6 appears N+1 edges later.
- Reset mid-mul:
  - Assert `rst` 4 edges after a mul `start` → no `done`; outputs at reset values.
  - Then add 1+1 → 2 after 1 edge.
